// File: rtl/control_pkg.sv
// control_pkg: shared states, instruction classes, opcode patterns and control encodings
package control_pkg;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    typedef enum logic [3:0] {
        CL_ANDREG, CL_ORRREG, CL_ADDREG, CL_SUBREG, CL_ADDIMM, CL_SUBIMM,
        CL_MOVZ, CL_B, CL_CBZ, CL_LDUR, CL_STUR, CL_ILLEGAL
    } iclass_t;

    localparam logic [10:0] OP_ANDREG = 11'b?0001010???;
    localparam logic [10:0] OP_ORRREG = 11'b?0101010???;
    localparam logic [10:0] OP_ADDREG = 11'b?0?01011???;
    localparam logic [10:0] OP_SUBREG = 11'b?1?01011???;
    localparam logic [10:0] OP_ADDIMM = 11'b?0?10001???;
    localparam logic [10:0] OP_SUBIMM = 11'b?1?10001???;
    localparam logic [10:0] OP_MOVZ   = 11'b110100101??;
    localparam logic [10:0] OP_B      = 11'b?00101?????;
    localparam logic [10:0] OP_CBZ    = 11'b?011010????;
    localparam logic [10:0] OP_LDUR   = 11'b??111000010;
    localparam logic [10:0] OP_STUR   = 11'b??111000000;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_MOVZ  = 4'b1000;

    localparam logic [1:0] SIGN_I  = 2'b00;
    localparam logic [1:0] SIGN_D  = 2'b01;
    localparam logic [1:0] SIGN_CB = 2'b10;
    localparam logic [1:0] SIGN_B  = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       reg2loc;
        logic       alusrc;
        logic       mem2reg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       uncond_branch;
        logic [3:0] aluop;
        logic [1:0] signop;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t exec_ctrl(iclass_t c);
        ctrl_t o;
        o = '0;
        case (c)
            CL_ANDREG: o.aluop = ALU_AND;
            CL_ORRREG: o.aluop = ALU_ORR;
            CL_ADDREG: o.aluop = ALU_ADD;
            CL_SUBREG: o.aluop = ALU_SUB;
            CL_ADDIMM: begin o.alusrc = 1'b1; o.aluop = ALU_ADD; end
            CL_SUBIMM: begin o.alusrc = 1'b1; o.aluop = ALU_SUB; end
            CL_MOVZ:   begin o.alusrc = 1'b1; o.aluop = ALU_MOVZ; end
            CL_LDUR, CL_STUR: begin
                o.reg2loc = 1'b1;
                o.alusrc  = 1'b1;
                o.signop  = SIGN_D;
                o.aluop   = ALU_ADD;
            end
            CL_CBZ: begin
                o.reg2loc = 1'b1;
                o.signop  = SIGN_CB;
                o.aluop   = ALU_PASSB;
            end
            CL_B:    o.signop = SIGN_B;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: maps the 11-bit LEGv8 opcode field to an instruction class
module opcode_classifier
    import control_pkg::*;
(
    input  logic [10:0] opcode,
    output iclass_t     cls
);

    // first matching pattern wins; anything unmatched is illegal
    always_comb begin
        casez (opcode)
            OP_ANDREG: cls = CL_ANDREG;
            OP_ORRREG: cls = CL_ORRREG;
            OP_ADDREG: cls = CL_ADDREG;
            OP_SUBREG: cls = CL_SUBREG;
            OP_ADDIMM: cls = CL_ADDIMM;
            OP_SUBIMM: cls = CL_SUBIMM;
            OP_MOVZ:   cls = CL_MOVZ;
            OP_B:      cls = CL_B;
            OP_CBZ:    cls = CL_CBZ;
            OP_LDUR:   cls = CL_LDUR;
            OP_STUR:   cls = CL_STUR;
            default:   cls = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: five-state LEGv8 sequencer with shared memory port arbitration
module multicycle_control
    import control_pkg::*;
(
    input  logic        CLK,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        iord,
    output logic        irwrite,
    output logic        pcwrite,
    output logic        reg2loc,
    output logic        alusrc,
    output logic        mem2reg,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        branch,
    output logic        uncond_branch,
    output logic [3:0]  aluop,
    output logic [1:0]  signop,
    output logic        instr_done,
    output logic        illegal
);

    state_t  state, state_nxt;
    iclass_t cls_q, cls_d;
    ctrl_t   raw, o;

    opcode_classifier u_classifier (
        .opcode (opcode),
        .cls    (cls_d)
    );

    // state register; the class is captured only while decoding
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= S_FETCH;
            cls_q <= CL_ILLEGAL;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE)
                cls_q <= cls_d;
        end
    end

    // next-state and control decode per state and latched class
    always_comb begin
        raw       = '0;
        state_nxt = state;
        case (state)
            S_FETCH: begin
                raw.mem_req = 1'b1;
                raw.memread = 1'b1;
                raw.irwrite = mem_ready;
                raw.pcwrite = mem_ready;
                state_nxt   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                raw.illegal    = (cls_d == CL_ILLEGAL);
                raw.instr_done = (cls_d == CL_ILLEGAL);
                state_nxt      = (cls_d == CL_ILLEGAL) ? S_FETCH : S_EXEC;
            end
            S_EXEC: begin
                raw               = exec_ctrl(cls_q);
                raw.branch        = (cls_q == CL_CBZ);
                raw.uncond_branch = (cls_q == CL_B);
                raw.instr_done    = (cls_q == CL_CBZ) || (cls_q == CL_B);
                state_nxt         = raw.instr_done ? S_FETCH :
                                    (cls_q == CL_LDUR || cls_q == CL_STUR) ? S_MEM : S_WB;
            end
            S_MEM: begin
                raw            = exec_ctrl(CL_LDUR);
                raw.mem_req    = 1'b1;
                raw.iord       = 1'b1;
                raw.memread    = (cls_q == CL_LDUR);
                raw.memwrite   = (cls_q == CL_STUR);
                raw.instr_done = mem_ready && (cls_q == CL_STUR);
                state_nxt      = !mem_ready ? S_MEM : (cls_q == CL_STUR) ? S_FETCH : S_WB;
            end
            S_WB: begin
                raw            = (cls_q == CL_LDUR) ? '0 : exec_ctrl(cls_q);
                raw.regwrite   = 1'b1;
                raw.mem2reg    = (cls_q == CL_LDUR);
                raw.instr_done = 1'b1;
                state_nxt      = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    assign o             = reset ? '0 : raw;
    assign mem_req       = o.mem_req;
    assign iord          = o.iord;
    assign irwrite       = o.irwrite;
    assign pcwrite       = o.pcwrite;
    assign reg2loc       = o.reg2loc;
    assign alusrc        = o.alusrc;
    assign mem2reg       = o.mem2reg;
    assign regwrite      = o.regwrite;
    assign memread       = o.memread;
    assign memwrite      = o.memwrite;
    assign branch        = o.branch;
    assign uncond_branch = o.uncond_branch;
    assign aluop         = o.aluop;
    assign signop        = o.signop;
    assign instr_done    = o.instr_done;
    assign illegal       = o.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-cycle scoreboard check of the multicycle sequencer
module tb_multicycle_control;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic mem_ready = 1'b0;
  logic [10:0] opcode = '0;
  logic mem_req, iord, irwrite, pcwrite, reg2loc, alusrc, mem2reg, regwrite;
  logic memread, memwrite, branch, uncond_branch, instr_done, illegal;
  logic [3:0] aluop;
  logic [1:0] signop;
  multicycle_control dut (
    .CLK(CLK), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
    .reg2loc(reg2loc), .alusrc(alusrc), .mem2reg(mem2reg), .regwrite(regwrite),
    .memread(memread), .memwrite(memwrite), .branch(branch),
    .uncond_branch(uncond_branch), .aluop(aluop), .signop(signop),
    .instr_done(instr_done), .illegal(illegal)
  );
  always #5 CLK = ~CLK;
  typedef struct packed {
    logic mem_req, iord, irwrite, pcwrite, reg2loc, alusrc, mem2reg, regwrite;
    logic memread, memwrite, branch, uncond_branch;
    logic [3:0] aluop;
    logic [1:0] signop;
    logic instr_done, illegal;
  } vec_t;
  typedef struct {
    string tag;
    logic rst;
    logic rdy;
    logic [10:0] op;
    vec_t exp;
  } step_t;
  typedef struct {
    string tag;
    vec_t exp;
  } expect_t;
  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_ILL = 4;
  step_t stim[$];
  expect_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  vec_t obs;
  assign obs = '{mem_req:mem_req, iord:iord, irwrite:irwrite, pcwrite:pcwrite,
                 reg2loc:reg2loc, alusrc:alusrc, mem2reg:mem2reg, regwrite:regwrite,
                 memread:memread, memwrite:memwrite, branch:branch,
                 uncond_branch:uncond_branch, aluop:aluop, signop:signop,
                 instr_done:instr_done, illegal:illegal};
  function automatic vec_t fetch_v(logic rdy);
    vec_t v = '0;
    v.mem_req = 1'b1;
    v.memread = 1'b1;
    v.irwrite = rdy;
    v.pcwrite = rdy;
    return v;
  endfunction
  function automatic vec_t ex_v(logic r2l, logic asrc, logic [1:0] sop, logic [3:0] aop,
                                logic br, logic ub);
    vec_t v = '0;
    v.reg2loc = r2l;
    v.alusrc = asrc;
    v.signop = sop;
    v.aluop = aop;
    v.branch = br;
    v.uncond_branch = ub;
    v.instr_done = br | ub;
    return v;
  endfunction
  task automatic push(string tag, logic rst, logic rdy, logic [10:0] op, vec_t e);
    stim.push_back('{tag, rst, rdy, op, e});
  endtask
  task automatic chk(string tag, vec_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic push_instr(string nm, logic [10:0] op, int kind, vec_t ex, int fw, int mw);
    vec_t d, m, w;
    for (int i = 0; i < fw; i++) push({nm, ".fetch_wait"}, 1'b0, 1'b0, ~op, fetch_v(1'b0));
    push({nm, ".fetch"}, 1'b0, 1'b1, ~op, fetch_v(1'b1));
    d = '0;
    d.illegal = (kind == K_ILL);
    d.instr_done = (kind == K_ILL);
    push({nm, ".decode"}, 1'b0, 1'b1, op, d);
    if (kind == K_ILL) return;
    push({nm, ".exec"}, 1'b0, 1'b1, ~op, ex);
    if (kind == K_BR) return;
    if (kind == K_LD || kind == K_ST) begin
      m = ex_v(1'b1, 1'b1, 2'b01, 4'b0010, 1'b0, 1'b0);
      m.mem_req = 1'b1;
      m.iord = 1'b1;
      m.memread = (kind == K_LD);
      m.memwrite = (kind == K_ST);
      for (int i = 0; i < mw; i++) push({nm, ".mem_wait"}, 1'b0, 1'b0, ~op, m);
      m.instr_done = (kind == K_ST);
      push({nm, ".mem"}, 1'b0, 1'b1, ~op, m);
      if (kind == K_ST) return;
    end
    w = (kind == K_LD) ? vec_t'('0) : ex;
    w.regwrite = 1'b1;
    w.mem2reg = (kind == K_LD);
    w.instr_done = 1'b1;
    push({nm, ".wb"}, 1'b0, 1'b1, ~op, w);
  endtask
  initial begin
    step_t s;
    expect_t e;
    vec_t st_ex;
    st_ex = ex_v(1'b1, 1'b1, 2'b01, 4'b0010, 1'b0, 1'b0);
    push("reset0", 1'b1, 1'b1, 11'h000, '0);
    push("reset1", 1'b1, 1'b1, 11'h7ff, '0);
    push_instr("ADDREG", 11'b10001011000, K_ALU, ex_v(0, 0, 2'b00, 4'b0010, 0, 0), 0, 0);
    push_instr("ANDREG", 11'b10001010000, K_ALU, ex_v(0, 0, 2'b00, 4'b0000, 0, 0), 1, 0);
    push_instr("ORRREG", 11'b10101010000, K_ALU, ex_v(0, 0, 2'b00, 4'b0001, 0, 0), 0, 0);
    push_instr("SUBREG", 11'b11001011000, K_ALU, ex_v(0, 0, 2'b00, 4'b0110, 0, 0), 0, 0);
    push_instr("ADDIMM", 11'b10010001000, K_ALU, ex_v(0, 1, 2'b00, 4'b0010, 0, 0), 0, 0);
    push_instr("SUBIMM", 11'b11010001000, K_ALU, ex_v(0, 1, 2'b00, 4'b0110, 0, 0), 0, 0);
    push_instr("LDUR", 11'b11111000010, K_LD, st_ex, 0, 2);
    push_instr("LDUR2", 11'b11111000010, K_LD, st_ex, 1, 0);
    push_instr("STUR", 11'b11111000000, K_ST, st_ex, 0, 0);
    push_instr("STUR2", 11'b11111000000, K_ST, st_ex, 0, 1);
    push_instr("CBZ", 11'b10110100000, K_BR, ex_v(1, 0, 2'b10, 4'b0111, 1, 0), 0, 0);
    push_instr("B", 11'b00010100000, K_BR, ex_v(0, 0, 2'b11, 4'b0000, 0, 1), 0, 0);
    push_instr("MOVZ", 11'b11010010100, K_ALU, ex_v(0, 1, 2'b00, 4'b1000, 0, 0), 0, 0);
    push_instr("ILL", 11'b00000000000, K_ILL, '0, 0, 0);
    push("ABT_ST.fetch", 1'b0, 1'b1, 11'h000, fetch_v(1'b1));
    push("ABT_ST.decode", 1'b0, 1'b1, 11'b11111000000, '0);
    push("ABT_ST.exec", 1'b0, 1'b1, 11'h000, st_ex);
    push("ABT_ST.mem_rst", 1'b1, 1'b1, 11'h000, '0);
    push("ABT_ST.post_rst", 1'b1, 1'b1, 11'h000, '0);
    push("ABT_ST.refetch", 1'b0, 1'b0, 11'h000, fetch_v(1'b0));
    push_instr("ADD_AFTER", 11'b10001011000, K_ALU, ex_v(0, 0, 2'b00, 4'b0010, 0, 0), 0, 0);
    push("ABT_F.fetch_wait", 1'b0, 1'b0, 11'h000, fetch_v(1'b0));
    push("ABT_F.fetch_rst", 1'b1, 1'b1, 11'h000, '0);
    push_instr("CBZ_AFTER", 11'b10110100000, K_BR, ex_v(1, 0, 2'b10, 4'b0111, 1, 0), 0, 0);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      @(posedge CLK);
      #1;
      reset = s.rst;
      mem_ready = s.rdy;
      opcode = s.op;
      sb.push_back('{s.tag, s.exp});
      @(negedge CLK);
      e = sb.pop_front();
      chk(e.tag, e.exp);
      if (s.rst)
        assert (!mem_req && !memread && !memwrite && !irwrite && !pcwrite && !regwrite) else begin
          miscompares++;
          $error("FAIL %s: outputs active during reset", e.tag);
        end
      if (!s.rdy && e.exp.mem_req)
        assert (mem_req && !irwrite && !pcwrite && !regwrite && !instr_done && iord === e.exp.iord) else begin
          miscompares++;
          $error("FAIL %s: memory wait not held", e.tag);
        end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the LEGv8 datapath. It replaces the purely combinational single-cycle decoder with a five-state FSM that walks each instruction through fetch, decode, execute, memory and write-back. It also arbitrates the single shared instruction/data memory port between the fetch and memory phases. It sits between the instruction register and the datapath, driving every mux select, enable and ALU control line.

## Interface
Parameters: none.

Ports:
- CLK  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  11  instruction bits [31:21] from the instruction register; sampled only in DECODE
- mem_ready  input  1  shared memory completes the current request this cycle
- mem_req  output  1  request to the shared memory port
- iord  output  1  memory address select: 0 = PC (fetch), 1 = ALU result (data)
- irwrite  output  1  load instruction register
- pcwrite  output  1  load PC with PC+4
- reg2loc  output  1  register read port 2 select: 0 = Rm, 1 = Rt
- alusrc  output  1  ALU B select: 0 = register, 1 = extended immediate
- mem2reg  output  1  write-back select: 1 = memory data, 0 = ALU
- regwrite  output  1  register file write enable
- memread  output  1  memory read strobe
- memwrite  output  1  memory write strobe
- branch  output  1  conditional (CBZ) PC update enable
- uncond_branch  output  1  unconditional (B) PC update enable
- aluop  output  4  AND 0000, ORR 0001, ADD 0010, SUB 0110, PassB 0111, MOVZ 1000
- signop  output  2  I-type 00, D-type 01, CB-type 10, B-type 11
- instr_done  output  1  one-cycle pulse on the last cycle of every instruction
- illegal  output  1  one-cycle pulse in DECODE when the opcode matches no class

## Operation
- Opcode classes are matched with casez, first match wins, in this order:
  - ANDREG ?0001010???
  - ORRREG ?0101010???
  - ADDREG ?0?01011???
  - SUBREG ?1?01011???
  - ADDIMM ?0?10001???
  - SUBIMM ?1?10001???
  - MOVZ 110100101??
  - B ?00101?????
  - CBZ ?011010????
  - LDUR ??111000010
  - STUR ??111000000
  - ILLEGAL: no match
- States: FETCH, DECODE, EXEC, MEM, WB.
- In every state, any output not listed for that state is 0. Outputs are never x.
- FETCH:
  - Drive mem_req=1, memread=1, iord=0.
  - If mem_ready=1: irwrite=1, pcwrite=1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Latch the opcode class into an internal class register.
  - ILLEGAL: illegal=1, instr_done=1, go to FETCH.
  - Any other class: go to EXEC.
- EXEC: drive the following per class, then transition.
  - R-type: reg2loc=0, alusrc=0, aluop per op; go to WB.
  - ADDIMM/SUBIMM: alusrc=1, signop=00, aluop ADD/SUB; go to WB.
  - MOVZ: alusrc=1, signop=00, aluop=1000; go to WB.
  - LDUR/STUR: reg2loc=1, alusrc=1, signop=01, aluop=ADD; go to MEM.
  - CBZ: reg2loc=1, alusrc=0, aluop=PassB, signop=10, branch=1, instr_done=1; go to FETCH.
  - B: signop=11, uncond_branch=1, instr_done=1; go to FETCH.
- MEM:
  - Drive mem_req=1, iord=1, reg2loc=1, alusrc=1, signop=01, aluop=ADD.
  - LDUR drives memread=1; STUR drives memwrite=1.
  - Stay in MEM until mem_ready=1.
  - Then STUR: instr_done=1, go to FETCH. LDUR: go to WB.
- WB:
  - Drive regwrite=1, with mem2reg=1 for LDUR and 0 otherwise.
  - Hold the EXEC ALU controls for non-load classes.
  - Drive instr_done=1 and go to FETCH.

## Timing
- Reset:
  - Next edge forces FETCH and clears the class register to ILLEGAL.
  - All outputs are 0 during the reset cycle; reset overrides mem_ready.
- Reset asserted mid-FETCH or mid-MEM aborts the instruction.
  - mem_req, memread and memwrite are 0 in the cycle after the reset edge.
  - No irwrite, pcwrite or regwrite is issued.
- First post-reset cycle is FETCH with mem_req=1.
- Latency with zero-wait memory (mem_ready=1 on the first request cycle):
  - R, I and MOVZ: 4 cycles
  - LDUR: 5 cycles
  - STUR: 4 cycles
  - B and CBZ: 3 cycles
  - Each stalled memory cycle adds 1.
- irwrite/pcwrite (FETCH) and the MEM exit are Mealy on mem_ready. All other outputs are Moore on state plus class register.
- Arbitration: mem_req is high only in FETCH and MEM, so the two requesters never overlap. iord is stable for every cycle mem_req is high.
- mem_ready outside FETCH and MEM is ignored.

## Structure
- Package control_pkg holds:
  - state enum
  - instruction-class enum
  - the eleven opcode casez constants
  - aluop and signop constants
- Sub-module opcode_classifier:
  - Combinational casez from 11-bit opcode to class enum.
  - Instantiated once; its output is registered in DECODE.
- FSM, output decode and class register live in multicycle_control.

## Test plan
- ADDREG 11'b10001011000, mem_ready tied 1:
  - FETCH→DECODE→EXEC→WB.
  - EXEC aluop=0010, alusrc=0.
  - WB regwrite=1, mem2reg=0.
  - instr_done on cycle 4.
- LDUR 11'b11111000010 with mem_ready low 2 cycles in MEM:
  - MEM holds memread=1, iord=1 for 3 cycles.
  - WB mem2reg=1, regwrite=1.
  - Total 7 cycles.
- STUR 11'b11111000000:
  - MEM memwrite=1, reg2loc=1, signop=01.
  - regwrite never asserted; done in 4 cycles.
- CBZ 11'b10110100000 then B 11'b00010100000:
  - CBZ EXEC: branch=1, signop=10.
  - B EXEC: uncond_branch=1, signop=11.
  - 3 cycles each.
- MOVZ 11'b11010010100 and opcode 11'b00000000000:
  - MOVZ EXEC aluop=1000, alusrc=1.
  - Zero opcode pulses illegal and instr_done in DECODE, then returns to FETCH.
- reset asserted in MEM of a STUR:
  - Next cycle: FETCH, memwrite=0, mem_req=0.
  - Following cycle: mem_req=1, iord=0.
